pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline stall/bubble/flush controller for the RISC-V IMV core.
- Arbitrates four hazard causes:
  - load-use hazard
  - multi-cycle MUL/DIV occupancy in EX
  - data-memory wait states
  - taken-branch flush
- Drives per-stage stall, bubble and flush vectors for the PC and every pipeline register.
- Replaces the single-cause, fixed 5-stage combinational stall logic. Adds a latency-counting FSM for the MUL/DIV unit.

Parameters:
- NUM_STAGES, 5: pipeline registers including PC. Index 0=PC, 1=IFID, 2=IDEX, 3=EXMEM, 4=MEMWB. Must be ≥ EX_STAGE+3.
- EX_STAGE, 2: index of the register feeding EX (IDEX).
- MUL_LAT, 1: MUL latency in cycles, ≥1.
- DIV_LAT, 34: DIV latency in cycles, ≥1.
- CNT_W, $clog2(max(MUL_LAT,DIV_LAT)+1): latency counter width.
- PERF_W, 32: performance counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- load_use_hazard  in  1  ID needs the result of the load currently in EX.
- mdu_start  in  1  MUL/DIV instruction present in EX. Held high while that instruction sits in EX.
- mdu_is_div  in  1  qualifies mdu_start: 1=DIV, 0=MUL.
- mem_req_valid  in  1  MEM stage has a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  branch/jump resolved taken in EX.
- stall  out  NUM_STAGES  per-register hold enable.
- bubble  out  NUM_STAGES  per-register NOP insert (bit 0 always 0).
- flush  out  NUM_STAGES  per-register kill of the current content.
- mdu_busy  out  1  FSM in BUSY.
- perf_lu_cnt  out  PERF_W  load-use stall cycles.
- perf_mdu_cnt  out  PERF_W  MUL/DIV stall cycles.
- perf_mem_cnt  out  PERF_W  memory-wait stall cycles.

Behaviour:
- Reset: async on rst_n=0. FSM=IDLE, cnt=0, perf counters=0. All outputs 0 while in reset and immediately after.
- A reset mid-operation (e.g. during a DIV) abandons the count.
- Stall point P: stall[0..P]=1, bubble[P+1]=1, all other stall/bubble bits 0.
- mem_wait = mem_req_valid & ~mem_ready.
- Cause priority, highest first:
  - mem_wait: P = EX_STAGE+1.
  - mdu_stall: P = EX_STAGE.
  - branch_taken: flush[1..EX_STAGE]=1, no stall. The younger instructions are killed.
  - load_use_hazard: P = EX_STAGE.
- A lower cause is fully masked when a higher cause is active:
  - branch_taken together with load_use_hazard gives flush only.
  - branch_taken together with mem_wait gives the stall only, no flush. The branch is held in EX and re-asserts.
- MDU FSM, states IDLE and BUSY. LAT = mdu_is_div ? DIV_LAT : MUL_LAT.
  - IDLE with mdu_start=1 and mem_wait=0 and LAT≥2: mdu_stall=1 combinationally this cycle; cnt←LAT-2; go to BUSY.
  - IDLE with LAT=1: no stall, stay IDLE.
  - IDLE with mem_wait=1: mdu_start is not accepted.
  - BUSY: mdu_start ignored (same held instruction).
  - BUSY with cnt≠0: mdu_stall=1; cnt decrements every cycle, including during mem_wait.
  - BUSY with cnt=0: mdu_stall=0. Go to IDLE only if mem_wait=0; otherwise stay BUSY with cnt=0. This prevents re-triggering on the held instruction.
  - Net effect: exactly LAT-1 stalled cycles per MUL/DIV when there is no memory wait. The instruction leaves EX at the end of cycle LAT.
- mdu_busy = (state==BUSY).
- Outputs other than FSM state are combinational from state and inputs. Zero-cycle latency to hazard inputs.
- Perf counters increment once per cycle in which their cause is the winning stall cause. They saturate at all-ones (no wrap).

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined: the three perf counters are implemented as described.
- Undefined: the counter registers are not built and perf_*_cnt are tied to 0. Ports remain.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - stage index constants STG_PC, STG_IFID, STG_IDEX, STG_EXMEM, STG_MEMWB
  - MDU state enum mdu_state_t {IDLE, BUSY}
  - cause enum hazard_cause_t {NONE, MEM, MDU, BRANCH, LOADUSE}
- One natural sub-module: mdu_latency_counter, containing the FSM, cnt, and the mdu_stall/mdu_busy generation.

Test Plan:
- load_use_hazard=1 for 1 cycle, other inputs 0 -> stall=5'b00111, bubble=5'b01000, flush=0 that cycle. All zero the next cycle.
- mdu_start=1, mdu_is_div=1 held until release, DIV_LAT=34 -> stall=00111/bubble=01000 for 33 consecutive cycles. Released on cycle 34. mdu_busy high for cycles 2-34.
- MUL with MUL_LAT=1 -> no stall, mdu_busy stays 0.
- branch_taken=1 and load_use_hazard=1 same cycle -> flush=5'b00110, stall=0, bubble=0.
- DIV in BUSY reaches cnt=0 while mem_wait=1 for 3 cycles -> stall=01111, bubble=10000 for those 3 cycles. FSM stays BUSY, then goes IDLE; no second DIV start.
- rst_n deasserted mid-DIV at cnt=10 -> all outputs 0 immediately. After release, a new DIV gives a full 33-cycle stall.
- With PIPE_HAZARD_PERF_CNT_EN: after the above sequence the perf counters match the per-cause cycle totals. Without the macro they read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//     - stage index constants for the pipeline registers (PC .. MEMWB)
//     - mdu_state_t    : MUL/DIV latency FSM states
//     - hazard_cause_t : which hazard cause won arbitration this cycle
//     - max_int        : helper used to size the latency counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        MEM     = 3'd1,
        MDU     = 3'd2,
        BRANCH  = 3'd3,
        LOADUSE = 3'd4
    } hazard_cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_latency_counter.sv
// -----------------------------------------------------------------------------
// mdu_latency_counter
//   Counts the occupancy of a multi-cycle MUL/DIV instruction sitting in EX and
//   requests a pipeline stall until its result is ready.
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     mdu_start    : MUL/DIV instruction present in EX (held while it sits there)
//     mdu_is_div   : 1 = DIV, 0 = MUL
//     mem_wait     : MEM stage is waiting on data memory
//     mdu_stall    : combinational stall request from the MDU
//     mdu_busy     : FSM state view (1 = BUSY); doubles as the FSM debug output
// -----------------------------------------------------------------------------
module mdu_latency_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = $clog2(max_int(MUL_LAT, DIV_LAT) + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdu_start,
    input  logic mdu_is_div,
    input  logic mem_wait,
    output logic mdu_stall,
    output logic mdu_busy
);

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat;

    assign lat = mdu_is_div ? DIV_LAT_C : MUL_LAT_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accept cycle already stalls, so BUSY is entered with LAT-2 cycles of
    // stall left; the cycle with cnt=0 is the one the result leaves EX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                // Not accepted while MEM waits: the pipe is frozen behind it.
                if (mdu_start && !mem_wait && (lat >= CNT_W'(2))) begin
                    mdu_stall = 1'b1;
                    cnt_d     = lat - CNT_W'(2);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mdu_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else if (!mem_wait) begin
                    // Staying BUSY under mem_wait keeps the still-held
                    // instruction from being accepted a second time.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdu_busy = (state_q == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline stall/bubble/flush controller. Arbitrates memory wait, MUL/DIV
//   occupancy, taken-branch flush and load-use hazards (highest priority first)
//   and drives per-register stall, bubble and flush vectors (index 0 = PC).
//
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     load_use_hazard     : ID needs the load result currently in EX
//     mdu_start/mdu_is_div: MUL/DIV in EX (held), 1 = DIV
//     mem_req_valid       : MEM stage has a data-memory access
//     mem_ready           : data memory completes the access this cycle
//     branch_taken        : branch/jump resolved taken in EX
//     stall/bubble/flush  : per-register hold / NOP insert / kill
//     mdu_busy            : MUL/DIV FSM in BUSY
//     perf_*_cnt          : saturating per-cause stall-cycle counters
//
//   Memory handshake: an access is presented while mem_req_valid=1 and
//   completes in the cycle mem_ready=1; every cycle with valid=1 and ready=0
//   is a wait cycle.
//
//   Build option: PIPE_HAZARD_PERF_CNT_EN builds the perf counters; without it
//   the perf_*_cnt outputs are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int EX_STAGE   = STG_IDEX,
    parameter int MUL_LAT    = 1,
    parameter int DIV_LAT    = 34,
    parameter int CNT_W      = $clog2(max_int(MUL_LAT, DIV_LAT) + 1),
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_use_hazard,
    input  logic                  mdu_start,
    input  logic                  mdu_is_div,
    input  logic                  mem_req_valid,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  mdu_busy,
    output logic [PERF_W-1:0]     perf_lu_cnt,
    output logic [PERF_W-1:0]     perf_mdu_cnt,
    output logic [PERF_W-1:0]     perf_mem_cnt
);

    logic          mem_wait;
    logic          mdu_stall;
    hazard_cause_t cause;
    logic          has_stall;
    int            stall_point;

    assign mem_wait = mem_req_valid & ~mem_ready;

    mdu_latency_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdu_start  (mdu_start),
        .mdu_is_div (mdu_is_div),
        .mem_wait   (mem_wait),
        .mdu_stall  (mdu_stall),
        .mdu_busy   (mdu_busy)
    );

    // Outputs are forced quiet while reset is asserted, even though the
    // hazard inputs may still be toggling.
    always_comb begin
        cause = NONE;
        if (rst_n) begin
            if (mem_wait)             cause = MEM;
            else if (mdu_stall)       cause = MDU;
            else if (branch_taken)    cause = BRANCH;
            else if (load_use_hazard) cause = LOADUSE;
        end
    end

    // Stall point: everything up to and including it holds, the register just
    // after it receives a bubble. A memory wait also freezes EX.
    always_comb begin
        has_stall   = (cause == MEM) || (cause == MDU) || (cause == LOADUSE);
        stall_point = (cause == MEM) ? EX_STAGE + 1 : EX_STAGE;
        stall       = '0;
        bubble      = '0;
        flush       = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stall[i]  = has_stall && (i <= stall_point);
            bubble[i] = has_stall && (i == stall_point + 1);
            flush[i]  = (cause == BRANCH) && (i >= STG_IFID) && (i <= EX_STAGE);
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_cnt  <= '0;
            perf_mdu_cnt <= '0;
            perf_mem_cnt <= '0;
        end else begin
            if ((cause == LOADUSE) && (perf_lu_cnt != '1))
                perf_lu_cnt <= perf_lu_cnt + PERF_W'(1);
            if ((cause == MDU) && (perf_mdu_cnt != '1))
                perf_mdu_cnt <= perf_mdu_cnt + PERF_W'(1);
            if ((cause == MEM) && (perf_mem_cnt != '1))
                perf_mem_cnt <= perf_mem_cnt + PERF_W'(1);
        end
    end
`else
    assign perf_lu_cnt  = '0;
    assign perf_mdu_cnt = '0;
    assign perf_mem_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl with a cycle-level reference model.
//   The model tracks the in-flight MUL/DIV instruction by elapsed cycles in EX
//   and derives stall/bubble/flush from the winning cause's stall point.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int NS      = 5;
    localparam int EX      = 2;
    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 34;
    localparam int PERF_W  = 32;
    localparam longint PERF_MAX = (longint'(1) << PERF_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          load_use_hazard = 1'b0;
    logic          mdu_start       = 1'b0;
    logic          mdu_is_div      = 1'b0;
    logic          mem_req_valid   = 1'b0;
    logic          mem_ready       = 1'b0;
    logic          branch_taken    = 1'b0;
    logic [NS-1:0] stall, bubble, flush;
    logic          mdu_busy;
    logic [PERF_W-1:0] perf_lu_cnt, perf_mdu_cnt, perf_mem_cnt;

    pipe_hazard_ctrl #(
        .NUM_STAGES (NS),
        .EX_STAGE   (EX),
        .MUL_LAT    (MUL_LAT),
        .DIV_LAT    (DIV_LAT),
        .PERF_W     (PERF_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_hazard (load_use_hazard),
        .mdu_start       (mdu_start),
        .mdu_is_div      (mdu_is_div),
        .mem_req_valid   (mem_req_valid),
        .mem_ready       (mem_ready),
        .branch_taken    (branch_taken),
        .stall           (stall),
        .bubble          (bubble),
        .flush           (flush),
        .mdu_busy        (mdu_busy),
        .perf_lu_cnt     (perf_lu_cnt),
        .perf_mdu_cnt    (perf_mdu_cnt),
        .perf_mem_cnt    (perf_mem_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int     m_elapsed = -1;  // cycles the accepted MUL/DIV has spent in EX, -1 = none
    int     m_lat     = 0;
    longint m_lu = 0, m_mdu = 0, m_mem = 0;
    logic [3*NS:0] exp_q[$];

    function automatic longint sat(input longint v);
        return (v > PERF_MAX) ? PERF_MAX : v;
    endfunction

    always @(negedge clk) begin : model_and_compare
        logic          mw, ms, fl, hs, e_busy;
        int            sp, cand;
        logic [NS-1:0] e_stall, e_bubble, e_flush;
        logic [3*NS:0] e;
        mw = 1'b0; ms = 1'b0; fl = 1'b0; hs = 1'b0; e_busy = 1'b0; sp = 0; cand = 0;
        if (!rst_n) begin
            m_elapsed = -1;
            m_lu = 0; m_mdu = 0; m_mem = 0;
        end else begin
            mw = mem_req_valid && !mem_ready;
            if (m_elapsed < 0 && mdu_start && !mw) begin
                cand = mdu_is_div ? DIV_LAT : MUL_LAT;
                if (cand >= 2) begin
                    m_elapsed = 0;
                    m_lat     = cand;
                end
            end
            ms     = (m_elapsed >= 0) && (m_elapsed < m_lat - 1);
            e_busy = (m_elapsed >= 1);
            if (mw)                   begin hs = 1'b1; sp = EX + 1; m_mem++; end
            else if (ms)              begin hs = 1'b1; sp = EX;     m_mdu++; end
            else if (branch_taken)    fl = 1'b1;
            else if (load_use_hazard) begin hs = 1'b1; sp = EX;     m_lu++;  end
            if (m_elapsed >= 0) begin
                if (m_elapsed >= m_lat - 1 && !mw) m_elapsed = -1;
                else                               m_elapsed++;
            end
        end
        e_stall  = hs ? NS'((1 << (sp + 1)) - 1) : '0;
        e_bubble = hs ? NS'(1 << (sp + 1)) : '0;
        e_flush  = fl ? NS'((1 << (EX + 1)) - 2) : '0;
        exp_q.push_back({e_stall, e_bubble, e_flush, e_busy});

        e = exp_q.pop_front();
        check("mdl_stall",  64'(stall),    64'(e[3*NS:2*NS+1]));
        check("mdl_bubble", 64'(bubble),   64'(e[2*NS:NS+1]));
        check("mdl_flush",  64'(flush),    64'(e[NS:1]));
        check("mdl_busy",   64'(mdu_busy), 64'(e[0]));
        // Counters reflect the cycles already completed, not this one.
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check("mdl_perf_lu",  64'(perf_lu_cnt),  64'(sat(m_lu  - ((rst_n && !mw && !ms && !branch_taken && load_use_hazard) ? 1 : 0))));
        check("mdl_perf_mdu", 64'(perf_mdu_cnt), 64'(sat(m_mdu - ((rst_n && !mw && ms) ? 1 : 0))));
        check("mdl_perf_mem", 64'(perf_mem_cnt), 64'(sat(m_mem - ((rst_n && mw) ? 1 : 0))));
`else
        check("mdl_perf_lu",  64'(perf_lu_cnt),  64'(0));
        check("mdl_perf_mdu", 64'(perf_mdu_cnt), 64'(0));
        check("mdl_perf_mem", 64'(perf_mem_cnt), 64'(0));
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic mid(); @(negedge clk); #1; endtask
    task automatic nxt(); @(posedge clk); #1; endtask

    task automatic clear_inputs();
        load_use_hazard = 1'b0; mdu_start = 1'b0; mdu_is_div = 1'b0;
        mem_req_valid = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_stall"},  64'(stall),    64'(0));
        check({name, "_bubble"}, 64'(bubble),   64'(0));
        check({name, "_flush"},  64'(flush),    64'(0));
        check({name, "_busy"},   64'(mdu_busy), 64'(0));
    endtask

    // Holds a DIV in EX until the stall drops, counting stalled cycles.
    task automatic run_div(input string name);
        int  n_stall = 0;
        int  rel     = 0;
        bit  done    = 0;
        mdu_start = 1'b1; mdu_is_div = 1'b1;
        for (int c = 1; c <= 60 && !done; c++) begin
            mid();
            check($sformatf("%s_busy_c%0d", name, c), 64'(mdu_busy), 64'(c >= 2));
            if (stall == 5'b00111 && bubble == 5'b01000) n_stall++;
            else begin done = 1; rel = c; end
            nxt();
        end
        mdu_start = 1'b0; mdu_is_div = 1'b0;
        check({name, "_stall_cycles"}, 64'(n_stall), 64'(33));
        check({name, "_release_cycle"}, 64'(rel), 64'(34));
        mid();
        check_quiet({name, "_after"});
        nxt();
    endtask

    task automatic check_perf(input string name, input int lu, input int mdu, input int mem);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check({name, "_lu"},  64'(perf_lu_cnt),  64'(lu));
        check({name, "_mdu"}, 64'(perf_mdu_cnt), 64'(mdu));
        check({name, "_mem"}, 64'(perf_mem_cnt), 64'(mem));
`else
        check({name, "_lu"},  64'(perf_lu_cnt),  64'(lu * 0));
        check({name, "_mdu"}, 64'(perf_mdu_cnt), 64'(mdu * 0));
        check({name, "_mem"}, 64'(perf_mem_cnt), 64'(mem * 0));
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state, with a hazard input active to show outputs stay quiet.
        load_use_hazard = 1'b1;
        repeat (3) nxt();
        mid();
        check_quiet("reset");
        check_perf("reset_perf", 0, 0, 0);
        nxt();
        load_use_hazard = 1'b0;
        rst_n = 1'b1;
        mid();
        check_quiet("post_reset");
        nxt();

        // Single load-use cycle.
        load_use_hazard = 1'b1;
        mid();
        check("lu_stall",  64'(stall),  64'(5'b00111));
        check("lu_bubble", 64'(bubble), 64'(5'b01000));
        check("lu_flush",  64'(flush),  64'(0));
        nxt();
        load_use_hazard = 1'b0;
        mid();
        check_quiet("lu_next");
        nxt();

        // Full DIV.
        run_div("div1");

        // MUL with single-cycle latency.
        mdu_start = 1'b1; mdu_is_div = 1'b0;
        mid();
        check_quiet("mul");
        nxt();
        mdu_start = 1'b0;
        mid();
        check_quiet("mul_next");
        nxt();

        // Branch masks load-use.
        branch_taken = 1'b1; load_use_hazard = 1'b1;
        mid();
        check("br_lu_flush",  64'(flush),  64'(5'b00110));
        check("br_lu_stall",  64'(stall),  64'(0));
        check("br_lu_bubble", 64'(bubble), 64'(0));
        nxt();
        load_use_hazard = 1'b0;

        // Memory wait masks the branch; branch re-asserts once memory completes.
        mem_req_valid = 1'b1; mem_ready = 1'b0;
        mid();
        check("br_mw_stall",  64'(stall),  64'(5'b01111));
        check("br_mw_bubble", 64'(bubble), 64'(5'b10000));
        check("br_mw_flush",  64'(flush),  64'(0));
        nxt();
        mem_ready = 1'b1;
        mid();
        check("br_mr_flush", 64'(flush), 64'(5'b00110));
        check("br_mr_stall", 64'(stall), 64'(0));
        nxt();
        clear_inputs();

        // DIV whose last cycle coincides with a 3-cycle memory wait.
        mdu_start = 1'b1; mdu_is_div = 1'b1;
        for (int c = 1; c <= 33; c++) begin mid(); nxt(); end
        mem_req_valid = 1'b1; mem_ready = 1'b0;
        for (int c = 34; c <= 36; c++) begin
            mid();
            check($sformatf("div_mw_stall_c%0d", c),  64'(stall),    64'(5'b01111));
            check($sformatf("div_mw_bubble_c%0d", c), 64'(bubble),   64'(5'b10000));
            check($sformatf("div_mw_busy_c%0d", c),   64'(mdu_busy), 64'(1));
            nxt();
        end
        mem_req_valid = 1'b0;
        mid();
        check("div_mw_end_stall", 64'(stall),    64'(0));
        check("div_mw_end_busy",  64'(mdu_busy), 64'(1));
        nxt();
        clear_inputs();
        mid();
        check_quiet("div_mw_idle");
        check_perf("perf_mid", 1, 66, 4);
        nxt();

        // Mixed: DIV offered under memory wait, load-use masked, mem wait mid-BUSY.
        mdu_start = 1'b1; mdu_is_div = 1'b1;
        mem_req_valid = 1'b1; mem_ready = 1'b0;
        repeat (2) begin
            mid();
            check("mix_mw_busy", 64'(mdu_busy), 64'(0));
            nxt();
        end
        mem_req_valid = 1'b0;
        mid();
        check("mix_accept_stall", 64'(stall), 64'(5'b00111));
        nxt();
        for (int c = 2; c <= 34; c++) begin
            load_use_hazard = (c >= 5 && c <= 8);
            mem_req_valid   = (c >= 12 && c <= 13);
            mid(); nxt();
        end
        clear_inputs();
        repeat (2) begin mid(); nxt(); end

        // Reset in the middle of a DIV (cycle 24 of the DIV, cnt=10).
        mdu_start = 1'b1; mdu_is_div = 1'b1;
        for (int c = 1; c <= 23; c++) begin mid(); nxt(); end
        rst_n = 1'b0;
        mid();
        check_quiet("mid_reset");
        check_perf("mid_reset_perf", 0, 0, 0);
        nxt();
        rst_n = 1'b1;
        run_div("div2");
        mid();
        check_perf("perf_end", 0, 33, 0);
        nxt();

        repeat (2) begin mid(); nxt(); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
